// File: rtl/pkt_sched_pkg.sv
// Shared definitions for the packet DWRR scheduler.
//   sched_state_t : scheduler FSM encoding (LOAD, SEL, XFER)
//   sat_add       : unsigned add clamped to a caller-given width w (w <= SAT_MAXW)
package pkt_sched_pkg;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_SEL  = 2'd1,
      ST_XFER = 2'd2
   } sched_state_t;

   localparam int SAT_MAXW = 32;

   function automatic logic [SAT_MAXW-1:0] sat_add(input logic [SAT_MAXW-1:0] a,
                                                   input logic [SAT_MAXW-1:0] b,
                                                   input int unsigned w);
      logic [SAT_MAXW:0] sum;
      logic [SAT_MAXW:0] one;
      logic [SAT_MAXW:0] lim;
      one    = '0;
      one[0] = 1'b1;
      sum    = {1'b0, a} + {1'b0, b};
      lim    = (one << w) - one;
      return (sum > lim) ? lim[SAT_MAXW-1:0] : sum[SAT_MAXW-1:0];
   endfunction

endpackage

// File: rtl/ff_en.sv
// Shared flop primitive: synchronous active-high reset, load enable.
//   i_clk, i_rst : clock, reset (RST_VAL loaded)
//   i_en, i_d    : load enable and data
//   o_q          : registered value
module ff_en #(
   parameter int              W       = 1,
   parameter logic [W-1:0]    RST_VAL = '0
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_en,
   input  logic [W-1:0]  i_d,
   output logic [W-1:0]  o_q
);

   always_ff @(posedge i_clk) begin
      if (i_rst)
         o_q <= RST_VAL;
      else if (i_en)
         o_q <= i_d;
   end

endmodule

// File: rtl/pkt_dwrr_sched_rr_next_ptr.sv
// Round-robin next-pointer search for the DWRR scheduler.
//   i_reqs : per-requester pending flags
//   i_ptr  : current pointer
//   o_nxt  : pointer to visit next
//   o_skip : requesters jumped over (their deficits must be cleared)
// Build option PKT_SCHED_SKIP_IDLE_EN: jump straight to the next requesting
// index; otherwise step to ptr+1 and report no skips.
module rr_next_ptr
   import pkt_sched_pkg::*;
#(
   parameter int NUM_REQS = 4,
   parameter int CNTWID   = $clog2(NUM_REQS)
) (
   input  logic [NUM_REQS-1:0] i_reqs,
   input  logic [CNTWID-1:0]   i_ptr,
   output logic [CNTWID-1:0]   o_nxt,
   output logic [NUM_REQS-1:0] o_skip
);

   logic [CNTWID-1:0] w_inc;

   // explicit wrap so non-power-of-2 counts never leave the valid range
   assign w_inc = (i_ptr == CNTWID'(NUM_REQS-1)) ? '0 : i_ptr + CNTWID'(1);

`ifdef PKT_SCHED_SKIP_IDLE_EN
   always_comb begin
      logic w_found;
      int   w_idx;
      w_found = 1'b0;
      w_idx   = 0;
      o_nxt   = w_inc;
      o_skip  = '0;
      for (int k = 1; k < NUM_REQS; k++) begin
         w_idx = (int'(i_ptr) + k) % NUM_REQS;
         if (!w_found) begin
            if (i_reqs[w_idx]) begin
               w_found = 1'b1;
               o_nxt   = CNTWID'(w_idx);
            end else begin
               o_skip[w_idx] = 1'b1;
            end
         end
      end
      // nobody waiting: plain step, nothing counts as skipped
      if (!w_found)
         o_skip = '0;
   end
`else
   logic w_unused_reqs;
   assign w_unused_reqs = ^i_reqs;
   assign o_nxt         = w_inc;
   assign o_skip        = '0;
`endif

endmodule

// File: rtl/pkt_dwrr_sched.sv
// Packet-level deficit-weighted round-robin scheduler for a multi-beat link.
//   clk, rst        : clock, synchronous active-high reset
//   blk             : downstream stall, freezes beat transfer
//   reqs, lens      : per-requester head-packet pending flag and length (0 = 1 beat)
//   input_quantums  : per-requester quantum added once per visit
//   gnt             : registered one-hot grant held for the whole packet
//   beat_vld, last  : beat transfers this cycle / final beat of the packet
//   busy            : packet transfer in progress
// Build option PKT_SCHED_SKIP_IDLE_EN (see rr_next_ptr) skips idle requesters.
//
// state | meaning
// LOAD  | add quantum[ptr] to def_cnt[ptr] (saturating)
// SEL   | grant head packet of ptr if deficit covers it, else move pointer
// XFER  | hold gnt[ptr], count beats down while not stalled
module pkt_dwrr_sched
   import pkt_sched_pkg::*;
#(
   parameter int NUM_REQS = 4,
   parameter int QWID     = 8,
   parameter int LWID     = 4,
   parameter int CNTWID   = $clog2(NUM_REQS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     blk,
   input  logic [NUM_REQS-1:0]      reqs,
   input  logic [NUM_REQS*LWID-1:0] lens,
   input  logic [NUM_REQS*QWID-1:0] input_quantums,
   output logic [NUM_REQS-1:0]      gnt,
   output logic                     beat_vld,
   output logic                     last,
   output logic                     busy
);

   sched_state_t        r_state, w_state_nxt;
   logic [CNTWID-1:0]   r_ptr, w_ptr_nxt, w_rr_nxt;
   logic                w_ptr_en;
   logic [NUM_REQS-1:0] w_rr_skip;
   logic [QWID-1:0]     r_def     [NUM_REQS];
   logic [QWID-1:0]     w_def_nxt [NUM_REQS];
   logic [NUM_REQS-1:0] w_def_en;
   logic [LWID-1:0]     r_beat_cnt, w_beat_nxt;
   logic                w_beat_en;
   logic [NUM_REQS-1:0] r_gnt, w_gnt_nxt;

   logic [LWID-1:0]     w_len_raw, w_len;
   logic [QWID-1:0]     w_qnt, w_def_cur, w_def_load;
   logic                w_req_cur, w_fits;

   assign w_len_raw  = lens[int'(r_ptr)*LWID +: LWID];
   assign w_len      = (w_len_raw == '0) ? LWID'(1) : w_len_raw;
   assign w_qnt      = input_quantums[int'(r_ptr)*QWID +: QWID];
   assign w_def_cur  = r_def[r_ptr];
   assign w_req_cur  = reqs[r_ptr];
   assign w_fits     = w_req_cur && (32'(w_def_cur) >= 32'(w_len));
   assign w_def_load = QWID'(sat_add(32'(w_def_cur), 32'(w_qnt), QWID));

   rr_next_ptr #(.NUM_REQS(NUM_REQS), .CNTWID(CNTWID)) u_rr (
      .i_reqs (reqs),
      .i_ptr  (r_ptr),
      .o_nxt  (w_rr_nxt),
      .o_skip (w_rr_skip)
   );

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= ST_LOAD;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_ptr_en    = 1'b0;
      w_beat_nxt  = r_beat_cnt;
      w_beat_en   = 1'b0;
      w_gnt_nxt   = '0;
      w_def_en    = '0;
      for (int i = 0; i < NUM_REQS; i++)
         w_def_nxt[i] = r_def[i];

      case (r_state)
         ST_LOAD: begin
            w_def_nxt[r_ptr] = w_def_load;
            w_def_en[r_ptr]  = 1'b1;
            w_state_nxt      = ST_SEL;
         end
         ST_SEL: begin
            if (w_fits) begin
               w_def_nxt[r_ptr] = w_def_cur - QWID'(w_len);
               w_def_en[r_ptr]  = 1'b1;
               w_beat_nxt       = w_len;
               w_beat_en        = 1'b1;
               w_gnt_nxt[r_ptr] = 1'b1;
               w_state_nxt      = ST_XFER;
            end else begin
               for (int i = 0; i < NUM_REQS; i++) begin
                  if (w_rr_skip[i]) begin
                     w_def_nxt[i] = '0;
                     w_def_en[i]  = 1'b1;
                  end
               end
               // an idle requester forfeits its accumulated deficit
               if (!w_req_cur) begin
                  w_def_nxt[r_ptr] = '0;
                  w_def_en[r_ptr]  = 1'b1;
               end
               w_ptr_nxt   = w_rr_nxt;
               w_ptr_en    = 1'b1;
               w_state_nxt = ST_LOAD;
            end
         end
         ST_XFER: begin
            w_gnt_nxt = r_gnt;
            if (!blk) begin
               w_beat_nxt = r_beat_cnt - LWID'(1);
               w_beat_en  = 1'b1;
               if (r_beat_cnt == LWID'(1)) begin
                  w_gnt_nxt   = '0;
                  w_state_nxt = ST_SEL;
               end
            end
         end
         default: w_state_nxt = ST_LOAD;
      endcase
   end

   ff_en #(.W(CNTWID)) u_ptr (
      .i_clk(clk), .i_rst(rst), .i_en(w_ptr_en), .i_d(w_ptr_nxt), .o_q(r_ptr)
   );

   ff_en #(.W(LWID)) u_beat (
      .i_clk(clk), .i_rst(rst), .i_en(w_beat_en), .i_d(w_beat_nxt), .o_q(r_beat_cnt)
   );

   ff_en #(.W(NUM_REQS)) u_gnt (
      .i_clk(clk), .i_rst(rst), .i_en(1'b1), .i_d(w_gnt_nxt), .o_q(r_gnt)
   );

   for (genvar g = 0; g < NUM_REQS; g++) begin : g_def
      ff_en #(.W(QWID)) u_def (
         .i_clk(clk), .i_rst(rst), .i_en(w_def_en[g]), .i_d(w_def_nxt[g]), .o_q(r_def[g])
      );
   end

   assign gnt      = r_gnt;
   assign busy     = (r_state == ST_XFER);
   assign beat_vld = (|r_gnt) & ~blk;
   assign last     = busy & (r_beat_cnt == LWID'(1)) & ~blk;

endmodule

// File: tb/tb_pkt_dwrr_sched.sv
module tb_pkt_dwrr_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        blk = 1'b0;
   logic [3:0]  reqs = '0;
   logic [15:0] lens = '0;
   logic [31:0] quantums = '0;
   logic [3:0]  gnt;
   logic        beat_vld, last, busy;

   pkt_dwrr_sched dut (
      .clk            (clk),
      .rst            (rst),
      .blk            (blk),
      .reqs           (reqs),
      .lens           (lens),
      .input_quantums (quantums),
      .gnt            (gnt),
      .beat_vld       (beat_vld),
      .last           (last),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [3:0] gnt;
      logic       last;
   } beat_t;

   beat_t exp_q[$];
   beat_t mon_e;
   int    n_tests = 0;
   int    n_fail  = 0;
   int    cyc     = 0;
   int    gnt_cycles = 0;
   int    last_cnt   = 0;

   // cycles since reset release; 0 while reset is held
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   // monitor: every transferred beat must match the head of the scoreboard
   always @(negedge clk) begin
      if (rst) begin
         gnt_cycles = 0;
         last_cnt   = 0;
      end else begin
         if (|gnt) gnt_cycles++;
         if (last) last_cnt++;
      end
      if (beat_vld) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL beat_unexpected: cyc=%0d gnt=%b last=%b, required no beat", cyc, gnt, last);
         end else begin
            mon_e = exp_q.pop_front();
            if (cyc != mon_e.cyc || gnt !== mon_e.gnt || last !== mon_e.last || busy !== 1'b1) begin
               n_fail++;
               $display("FAIL beat: got cyc=%0d gnt=%b last=%b busy=%b, required cyc=%0d gnt=%b last=%b busy=1",
                        cyc, gnt, last, busy, mon_e.cyc, mon_e.gnt, mon_e.last);
            end
         end
      end else if (last) begin
         n_tests++;
         n_fail++;
         $display("FAIL last_without_beat: cyc=%0d last=1, required 0", cyc);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic push_pkt(input int req, input int len, input int start);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.cyc  = start + i;
         b.gnt  = 4'(1 << req);
         b.last = (i == len - 1);
         exp_q.push_back(b);
      end
   endtask

   task automatic push_beat(input int c, input logic [3:0] g, input logic l);
      beat_t b;
      b.cyc  = c;
      b.gnt  = g;
      b.last = l;
      exp_q.push_back(b);
   endtask

   task automatic wait_cyc(input int n);
      int guard;
      guard = 0;
      while (cyc < n && guard < 5000) begin
         @(posedge clk); #1;
         guard++;
      end
      if (cyc < n) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_cyc: reached cyc %0d, required %0d", cyc, n);
      end
   endtask

   task automatic start_scn(input logic [31:0] q, input logic [15:0] l, input logic [3:0] r);
      rst      = 1'b1;
      quantums = q;
      lens     = l;
      reqs     = r;
      blk      = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;
   endtask

   task automatic end_scn(input string nm, input int n);
      wait_cyc(n);
      rst = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_pending: %0d beats outstanding, required 0", nm, exp_q.size());
      end
      exp_q.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int r2;
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("rst_gnt",      32'(gnt),      32'h0);
      chk("rst_beat_vld", 32'(beat_vld), 32'h0);
      chk("rst_last",     32'(last),     32'h0);
      chk("rst_busy",     32'(busy),     32'h0);
      @(posedge clk); #1;

      // equal weights: two 4-beat packets per requester, in order
      for (int r = 0; r < 4; r++) begin
         push_pkt(r, 4, 12*r + 2);
         push_pkt(r, 4, 12*r + 7);
      end
      start_scn(32'h08080808, 16'h4444, 4'b1111);
      end_scn("equal", 48);

      // 2:1 weighting, requesters 2 and 3 idle
`ifdef PKT_SCHED_SKIP_IDLE_EN
      r2 = 34;
`else
      r2 = 38;
`endif
      push_pkt(0, 4, 2);  push_pkt(0, 4, 7);
      push_pkt(0, 4, 12); push_pkt(0, 4, 17);
      push_pkt(1, 4, 24); push_pkt(1, 4, 29);
      push_pkt(0, 4, r2 + 2);
      start_scn(32'h08080810, 16'h4444, 4'b0011);
      end_scn("weighted", r2 + 6);

      // quantum 6 vs length 4: leftover deficit carries to the next visit
`ifdef PKT_SCHED_SKIP_IDLE_EN
      push_pkt(0, 4, 2); push_pkt(0, 4, 11); push_pkt(0, 4, 16);
      start_scn(32'h08080806, 16'h4444, 4'b0001);
      end_scn("carry", 21);
`else
      push_pkt(0, 4, 2); push_pkt(0, 4, 15); push_pkt(0, 4, 20);
      start_scn(32'h08080806, 16'h4444, 4'b0001);
      end_scn("carry", 25);
`endif

      // request drops in SEL with a sufficient deficit: cleared, no grant
`ifdef PKT_SCHED_SKIP_IDLE_EN
      push_pkt(0, 4, 6);
`else
      push_pkt(0, 4, 10);
`endif
      start_scn(32'h08080804, 16'h4444, 4'b0001);
      wait_cyc(1);
      reqs = 4'b0000;
      wait_cyc(2);
      reqs = 4'b0001;
`ifdef PKT_SCHED_SKIP_IDLE_EN
      end_scn("drop", 11);
`else
      end_scn("drop", 15);
`endif

      // stall: blk in LOAD/SEL is ignored, 3-cycle stall after beat 2
      push_beat(2, 4'b0001, 1'b0);
      push_beat(3, 4'b0001, 1'b0);
      push_beat(7, 4'b0001, 1'b0);
      push_beat(8, 4'b0001, 1'b1);
      start_scn(32'h08080804, 16'h4444, 4'b0001);
      blk = 1'b1;
      wait_cyc(2);
      blk = 1'b0;
      wait_cyc(4);
      blk = 1'b1;
      wait_cyc(7);
      blk = 1'b0;
      wait_cyc(10);
      chk("stall_gnt_cycles", 32'(gnt_cycles), 32'd7);
      chk("stall_last_count", 32'(last_cnt),   32'd1);
      end_scn("stall", 10);

      // zero length field means a single beat
      push_pkt(0, 1, 2); push_pkt(0, 1, 4);
      push_pkt(0, 1, 6); push_pkt(0, 1, 8);
      start_scn(32'h08080804, 16'h4440, 4'b0001);
      end_scn("len0", 10);

      // reset in the middle of a packet
      push_beat(2, 4'b0001, 1'b0);
      push_beat(3, 4'b0001, 1'b0);
      start_scn(32'h08080808, 16'h4444, 4'b0001);
      wait_cyc(3);
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst_gnt",      32'(gnt),      32'h0);
      chk("midrst_busy",     32'(busy),     32'h0);
      chk("midrst_last",     32'(last),     32'h0);
      chk("midrst_beat_vld", 32'(beat_vld), 32'h0);
      chk("midrst_pending",  32'(exp_q.size()), 32'h0);
      exp_q.delete();
      push_pkt(0, 4, 2); push_pkt(0, 4, 7);
      @(posedge clk); #1;
      rst = 1'b0;
      end_scn("after_rst", 12);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pkt_dwrr_sched.md
# pkt_dwrr_sched

Packet-level deficit-weighted round-robin scheduler for a shared multi-beat output link. Each of NUM_REQS requesters presents a request and the beat length of its head packet. The block grants whole packets and holds a one-hot grant until the last beat has transferred. A downstream stall input (blk) freezes the transfer. It sits between the per-requester packet queues and the shared link mux, and drives the mux select and end-of-packet framing.

## Interface
- NUM_REQS, 4, number of requesters
- QWID, 8, quantum and deficit counter width
- LWID, 4, packet length field width in beats
- CNTWID, $clog2(NUM_REQS), round-robin pointer width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- blk  in  1  downstream stall; no beat transfers while high
- reqs  in  NUM_REQS  head packet pending, per requester
- lens  in  NUM_REQS*LWID  head packet length in beats, requester i at [(i+1)*LWID-1:i*LWID]
- input_quantums  in  NUM_REQS*QWID  per-requester quantum, same packing as lens
- gnt  out  NUM_REQS  one-hot grant, registered, held for the whole packet
- beat_vld  out  1  a beat transfers this cycle (|gnt & ~blk)
- last  out  1  final beat of the packet transfers this cycle
- busy  out  1  a packet transfer is in progress (state XFER)

## Operation
- State: pointer ptr (CNTWID bits), def_cnt[i] (QWID bits each), beat_cnt (LWID bits), FSM {LOAD, SEL, XFER}.
- A lens value of 0 is treated as 1.
- LOAD: def_cnt[ptr] <= def_cnt[ptr] + quantum[ptr], saturating at 2^QWID-1. Next state is SEL.
- SEL, grant case (reqs[ptr] & def_cnt[ptr] >= len[ptr]):
  - def_cnt[ptr] -= len[ptr].
  - beat_cnt <= len[ptr].
  - Next state is XFER.
- SEL, no-grant case:
  - If ~reqs[ptr], clear def_cnt[ptr] to 0. Otherwise retain it.
  - ptr <= next pointer. Next state is LOAD.
- XFER:
  - gnt[ptr] = 1.
  - Each cycle with ~blk, beat_cnt decrements.
  - last = (beat_cnt == 1) & ~blk.
  - After the last beat, next state is SEL, with ptr unchanged and no quantum added.
- reqs and lens are ignored during XFER. The requester holds its packet until last.
- Quantum 0 with a nonzero deficit shortfall: that requester is never served. This is legal and gives the requester zero weight.
- NUM_REQS that is not a power of 2: the pointer wraps from NUM_REQS-1 to 0.

## Timing
- After reset: ptr=0, every def_cnt=0, state LOAD, beat_cnt=0. Outputs gnt=0, beat_vld=0, last=0, busy=0.
- SEL decision to first gnt cycle: 1 cycle.
- A packet of L beats with no stall occupies exactly L XFER cycles, and gnt falls the cycle after last.
- Back-to-back packets from the same requester have 1 idle cycle between them (SEL).
- Moving to another requester costs 2 cycles (SEL then LOAD) before its own SEL.
- blk high in XFER: beat_cnt holds, and gnt stays asserted. blk has no effect in LOAD or SEL.
- rst mid-XFER: gnt drops the next cycle, last is not asserted, and all state is reset.
- reqs[ptr] falling in SEL the same cycle its deficit would suffice: there is no grant, and def_cnt[ptr] is cleared.

## Configuration
- PKT_SCHED_SKIP_IDLE_EN defined:
  - The next pointer is the first index after ptr, cyclically and excluding ptr, that has reqs high. If none has reqs high, it is ptr+1.
  - Non-requesting requesters skipped over have def_cnt cleared in the same cycle.
- PKT_SCHED_SKIP_IDLE_EN undefined:
  - The next pointer is ptr+1 with wrap.
  - Idle requesters are visited one at a time, each taking LOAD then SEL.

## Structure
- Shared package pkt_sched_pkg holds:
  - the FSM state typedef (LOAD, SEL, XFER);
  - a saturating-add function parameterized by width.
- Sub-module rr_next_ptr (reqs, ptr -> next ptr) contains the macro-dependent pointer search.
- Registers use the team's shared FF primitive with enable.

## Test plan
- Defaults, quantums all 8, lens all 4, reqs=1111, blk=0 -> each requester gets 2 packets per round in order 0,0,1,1,2,2,3,3. gnt is held 4 cycles each with last on the 4th beat.
- Quantums {q0=16, q1=8}, lens 4, reqs=0011 -> 4 packets of requester 0 then 2 of requester 1 per round.
  - Macro off: 2 cycles each spent at ptr 2 and ptr 3.
  - Macro on: no cycles spent at ptr 2 or ptr 3.
- Requester 0: quantum 6, len 4, always requesting -> visit 1 grants 1 packet and leaves def 2; visit 2 has def 8, grants 2 packets and leaves def 0.
- Requester 0 with def 4 drops reqs in SEL -> def_cnt[0] becomes 0 and ptr advances. On the next visit def equals exactly the quantum.
- XFER of 4 beats with blk high for 3 cycles after beat 2 -> gnt is held 7 cycles, beat_vld pulses 4 times, and last is asserted once.
- rst asserted on beat 2 of a 4-beat packet -> the next cycle has gnt=0, busy=0 and state LOAD at ptr 0 with all deficits 0, and last never fires.
